deser_feed_arbiter: RTL and testbench

- Round-robin arbiter and bit sequencer that feeds the serial deserializer from two byte requesters.
- Waits for the deserializer's ready status, then grants one requester and latches its byte.
- Shifts the byte out LSB-first on a 1-bit data line, with a timed write strobe per bit.
- Sits between on-chip byte producers and the deserializer → queue datapath, in the same clock domain.

---
 rtl/deser_feed_arbiter.sv | 139 +++++++++++++
 tb/tb_deser_feed_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/deser_feed_arbiter.sv
// deser_feed_arbiter: round-robin arbiter between two byte requesters that
// feeds a serial deserializer. A granted byte is latched and shifted out
// LSB-first on data_out, with one timed write_out strobe per bit.
module deser_feed_arbiter #(
  parameter int START_DELAY  = 10,
  parameter int PULSE_CYCLES = 10,
  parameter int GAP_CYCLES   = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  input  logic       status_in,
  output logic       data_out,
  output logic       write_out,
  output logic       busy_out,
  output logic       grant_out
);

  // One shared phase counter, wide enough for the longest phase.
  localparam int MAX_PHASE = (START_DELAY > PULSE_CYCLES)
                           ? ((START_DELAY > GAP_CYCLES) ? START_DELAY : GAP_CYCLES)
                           : ((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES);
  localparam int CW = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

  localparam logic [CW-1:0] DELAY_LAST = CW'(START_DELAY - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            grant_q, grant_d;
  logic            ack_a_q, ack_a_d;
  logic            ack_b_q, ack_b_d;
  logic            sel_b;

  // On a tie the requester that was not served last wins; otherwise whoever asks.
  assign sel_b = (req_a && req_b) ? ~grant_q : req_b;

  // State and datapath registers; grant resets to B so that A wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      byte_q  <= 8'd0;
      grant_q <= 1'b1;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      grant_q <= grant_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
    end
  end

  // Next-state logic: grant from IDLE only, then time DELAY/PULSE/GAP per bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    grant_d = grant_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (status_in && (req_a || req_b)) begin
          grant_d = sel_b;
          byte_d  = sel_b ? data_b : data_a;
          ack_a_d = ~sel_b;
          ack_b_d = sel_b;
          idx_d   = 3'd0;
          cnt_d   = '0;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          cnt_d   = '0;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = PULSE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode straight from registers; data_out holds its bit through the gap.
  assign write_out = (state_q == PULSE);
  assign data_out  = ((state_q == PULSE) || (state_q == GAP)) ? byte_q[idx_q] : 1'b0;
  assign busy_out  = (state_q != IDLE);
  assign grant_out = grant_q;
  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;

endmodule

// File: tb/tb_deser_feed_arbiter.sv
// Bench for deser_feed_arbiter: a transaction-level reference model is checked
// every cycle, plus table-driven arbitration vectors and directed corner cases.
module tb_deser_feed_arbiter;

  localparam int SD  = 3;
  localparam int P   = 2;
  localparam int G   = 2;
  localparam int TOT = SD + 8 * (P + G);

  logic       clock = 1'b0;
  logic       reset;
  logic       req_a, req_b, status_in;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b, data_out, write_out, busy_out, grant_out;

  deser_feed_arbiter #(
    .START_DELAY (SD),
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_a    (req_a),
    .data_a   (data_a),
    .ack_a    (ack_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .ack_b    (ack_b),
    .status_in(status_in),
    .data_out (data_out),
    .write_out(write_out),
    .busy_out (busy_out),
    .grant_out(grant_out)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a transfer is just "cycle k of TOT since the grant".
  bit         m_act   = 1'b0;
  int         m_k     = 0;
  logic [7:0] m_byte  = 8'd0;
  logic       m_grant = 1'b1;
  logic       m_acka  = 1'b0;
  logic       m_ackb  = 1'b0;

  function automatic logic [5:0] m_out();
    logic d, w, b;
    int   j;
    d = 1'b0; w = 1'b0; b = 1'b0;
    if (m_act) begin
      b = 1'b1;
      if (m_k >= SD) begin
        j = m_k - SD;
        w = ((j % (P + G)) < P);
        d = m_byte[j / (P + G)];
      end
    end
    return {m_acka, m_ackb, d, w, b, m_grant};
  endfunction

  task automatic model_edge();
    logic sel;
    if (reset) begin
      m_act = 1'b0; m_acka = 1'b0; m_ackb = 1'b0; m_grant = 1'b1; m_k = 0;
    end else begin
      m_acka = 1'b0; m_ackb = 1'b0;
      if (m_act) begin
        m_k++;
        if (m_k == TOT) m_act = 1'b0;
      end else if (status_in && (req_a || req_b)) begin
        sel     = (req_a && req_b) ? ~m_grant : req_b;
        m_grant = sel;
        m_byte  = sel ? data_b : data_a;
        m_acka  = ~sel;
        m_ackb  = sel;
        m_act   = 1'b1;
        m_k     = 0;
      end
    end
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("cycle", {58'd0, ack_a, ack_b, data_out, write_out, busy_out, grant_out}, {58'd0, m_out()});
  endtask

  // Called right after a grant edge: follows the byte to busy_out falling.
  task automatic run_xfer(input string tag, input logic [7:0] exp_byte, input bit drop_status);
    logic [63:0] wmask, emask;
    logic [7:0]  cap;
    logic        prev_w;
    int          n, nb;
    wmask = '0; emask = '0; cap = 8'd0; prev_w = 1'b0; n = 0; nb = 0;
    req_a = 1'b0; req_b = 1'b0;
    while (busy_out && n < 200) begin
      wmask[n] = write_out;
      if (write_out && !prev_w) begin
        if (nb < 8) cap[nb] = data_out;
        nb++;
      end
      prev_w = write_out;
      if (drop_status && n == SD + 3 * (P + G)) status_in = 1'b0;
      data_a = 8'($urandom); data_b = 8'($urandom);
      step();
      n++;
    end
    for (int k = 0; k < TOT; k++)
      emask[k] = (k >= SD) && (((k - SD) % (P + G)) < P);
    chk({tag, "_busy_len"}, n, TOT);
    chk({tag, "_pulses"}, nb, 8);
    chk({tag, "_byte"}, cap, exp_byte);
    chk({tag, "_wr_pattern"}, wmask, emask);
    $display("xfer %s: byte=%02h cycles=%0d pulses=%0d", tag, cap, n, nb);
    status_in = 1'b1;
  endtask

  typedef struct {
    logic       ra, rb;
    logic [7:0] da, db;
    logic       ea, eb, eg;
    logic [7:0] ebyte;
  } vec_t;

  vec_t tbl[7];
  bit   pa, pb;

  initial begin
    // Arbitration vectors, applied in order from reset (grant_out starts at 1).
    tbl[0] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5}; // tie -> A
    tbl[1] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C}; // tie -> B
    tbl[2] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5}; // third tie -> A
    tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A}; // B alone
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3}; // B alone again
    tbl[5] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0, 8'h0F}; // tie after B -> A
    tbl[6] = '{1'b1, 1'b0, 8'h99, 8'h00, 1'b1, 1'b0, 1'b0, 8'h99}; // single byte 99

    reset = 1'b1; req_a = 1'b1; req_b = 1'b0; status_in = 1'b1;
    data_a = 8'h11; data_b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ack_a", ack_a, 1'b0);
      chk("rst_outs", {data_out, write_out, busy_out, grant_out}, 4'b0001);
    end
    reset = 1'b0; req_a = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      req_a = tbl[i].ra; req_b = tbl[i].rb;
      data_a = tbl[i].da; data_b = tbl[i].db;
      status_in = 1'b1;
      step();
      chk($sformatf("vec%0d_ack", i), {ack_a, ack_b}, {tbl[i].ea, tbl[i].eb});
      chk($sformatf("vec%0d_grant", i), grant_out, tbl[i].eg);
      run_xfer($sformatf("vec%0d", i), tbl[i].ebyte, 1'b0);
    end

    // Status gating: B waits while the deserializer is not ready.
    req_b = 1'b1; data_b = 8'hB7; status_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("gate_idle", {ack_b, write_out, busy_out}, 3'b000);
    end
    status_in = 1'b1;
    step();
    chk("gate_ack_b", ack_b, 1'b1);
    run_xfer("gate", 8'hB7, 1'b0);

    // Status dropping mid-transfer is ignored.
    req_a = 1'b1; data_a = 8'h2D;
    step();
    chk("drop_ack_a", ack_a, 1'b1);
    run_xfer("drop", 8'h2D, 1'b1);

    // Reset during the bit-3 pulse abandons the byte; held request is re-served.
    req_a = 1'b1; data_a = 8'h6E;
    step();
    chk("mid_ack_a", ack_a, 1'b1);
    for (int i = 0; i < SD + 3 * (P + G); i++) step();
    chk("mid_in_pulse", write_out, 1'b1);
    reset = 1'b1;
    step();
    chk("mid_rst_outs", {ack_a, data_out, write_out, busy_out, grant_out}, 5'b00001);
    reset = 1'b0;
    step();
    chk("mid_reack", ack_a, 1'b1);
    run_xfer("mid_resend", 8'h6E, 1'b0);

    // Randomized traffic against the model.
    pa = 1'b0; pb = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (ack_a) begin pa = 1'b0; $display("rand ack_a byte=%02h", m_byte); end
      if (ack_b) begin pb = 1'b0; $display("rand ack_b byte=%02h", m_byte); end
      if (!pa && ($urandom % 8 == 0)) begin pa = 1'b1; data_a = 8'($urandom); end
      else if (pa && ($urandom % 64 == 0)) pa = 1'b0;
      if (!pb && ($urandom % 8 == 0)) begin pb = 1'b1; data_b = 8'($urandom); end
      else if (pb && ($urandom % 64 == 0)) pb = 1'b0;
      if (!pa) data_a = 8'($urandom);
      if (!pb) data_b = 8'($urandom);
      req_a = pa; req_b = pb;
      status_in = ($urandom % 4 != 0);
      reset = ($urandom % 700 == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
